matbi_stream_downsizer: RTL and testbench
=========================================

# matbi_stream_downsizer

Wide-to-narrow valid/ready stream converter. It accepts one S_DATA_WIDTH beat and emits it as RATIO consecutive M_DATA_WIDTH beats, least-significant slice first, carrying packet `last` onto the final slice. It sits on the downstream side of the stream path, where wide data from compute or DMA blocks feeds narrower consumers. It pairs with the skid-buffer register slice, which may sit on either side of it.

## Interface
- S_DATA_WIDTH, 32, input beat width; must equal RATIO × M_DATA_WIDTH
- RATIO, 4, narrow beats per wide beat; integer ≥ 1
- M_DATA_WIDTH, S_DATA_WIDTH/RATIO, output beat width (derived localparam)
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready at posedge
- s_data  in  S_DATA_WIDTH  wide input beat
- s_last  in  1  input beat is last of packet
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_data  out  M_DATA_WIDTH  narrow output beat
- m_last  out  1  final slice of a beat with s_last set

## Operation
- Internal state:
  - buf_data (S_DATA_WIDTH) and buf_last: hold the accepted wide beat.
  - idx: slice counter, width max(1, clog2(RATIO)), range 0..RATIO-1.
  - full: buffer holds an unsent beat.
- States:
  - EMPTY (full=0): m_valid=0, s_ready=1.
  - SEND (full=1): m_valid=1.
- Outputs:
  - m_data = buf_data[idx*M_DATA_WIDTH +: M_DATA_WIDTH].
  - m_last = buf_last && (idx == RATIO-1).
- Output handshake (m_valid && m_ready):
  - idx < RATIO-1: idx increments.
  - idx == RATIO-1: idx returns to 0. If s_valid is high in the same cycle, the new beat is loaded and the block stays in SEND. Otherwise it goes to EMPTY.
- s_ready = ~rst && (~full || (m_ready && idx == RATIO-1)).
  - This is combinational from m_ready, so the block keeps full throughput with no bubble between wide beats.
- Load on s_valid && s_ready: buf_data ← s_data, buf_last ← s_last, idx ← 0, full ← 1.
- AXI-stream rules on the output:
  - m_valid never depends on m_ready.
  - Once m_valid is asserted, m_data and m_last hold stable until the handshake.
- RATIO=1: the block degenerates to a one-entry pipeline stage. idx is tied to 0 and every beat carries s_last directly to m_last.
- S_DATA_WIDTH not divisible by RATIO is illegal; the implementation flags it with an elaboration-time check.

## Timing
- Reset values (rst high at posedge): full=0, idx=0, buf_data=0, buf_last=0. This gives m_valid=0, m_data=0, m_last=0.
- s_ready is 0 during every cycle rst is high and 1 from the first cycle after rst deasserts.
- Latency: a beat accepted at edge k appears as slice 0 on m_data at cycle k+1 (m_valid high after edge k).
- Throughput: one narrow beat per cycle with m_ready held high, continuous across wide beats.
- Wide acceptance rate is at most 1 per RATIO cycles.
- Backpressure:
  - m_ready low freezes idx and the outputs.
  - s_ready stays low while full, except in the cycle when the last slice completes its handshake.
- Simultaneous last-slice handshake and new input: the new beat's slice 0 appears the next cycle.
- Reset mid-packet: the buffered beat is discarded. Output restarts from idx 0 with the first beat accepted after reset. No partial slices are emitted.

## Test plan
- Single beat, S=32, RATIO=4, s_data=0x44332211, s_last=1, m_ready=1:
  - m_data = 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles starting 1 cycle after accept.
  - m_last=1 only with 0x44; m_valid=0 afterwards.
- Back-to-back beats 0x44332211 then 0x88776655, s_valid held high, m_ready=1:
  - 8 output beats, no bubble.
  - s_ready=1 in the cycle 0x44 is handshaken.
- Backpressure: m_ready low for 3 cycles while 0x22 is presented:
  - m_data holds 0x22 and m_valid stays 1.
  - s_ready=0 throughout; the sequence resumes 0x22, 0x33, 0x44.
- Reset mid-beat: assert rst for one cycle after 0x11 and 0x22 are sent:
  - m_valid=0 the next cycle; s_ready=0 during rst.
  - The next beat 0xDDCCBBAA emits 0xAA first.
- s_last=0 on all beats: m_last never asserts across 3 wide beats.
- RATIO=1, S=M=8: 0x5A with s_last=1 appears as m_data=0x5A, m_last=1 one cycle after accept; sustains 1 beat per cycle.

Source files
------------

// File: rtl/matbi_stream_downsizer_if.sv
// Valid/ready stream bundle used on both sides of matbi_stream_downsizer.
// Parameters: DATA_WIDTH - payload width.
// Signals:    valid, ready, data[DATA_WIDTH-1:0], last.
// Modports:   master drives valid/data/last and samples ready;
//             slave samples valid/data/last and drives ready.
interface matbi_stream_downsizer_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/matbi_stream_downsizer.sv
// Wide-to-narrow stream converter: each accepted S_DATA_WIDTH beat is emitted
// as RATIO M_DATA_WIDTH beats, least-significant slice first; the wide beat's
// last flag is carried on its final slice only.
// Ports:
//   clk - clock, all logic on posedge
//   rst - synchronous active-high reset
//   s   - slave stream, S_DATA_WIDTH payload (valid/ready/data/last)
//   m   - master stream, M_DATA_WIDTH payload (valid/ready/data/last)
module matbi_stream_downsizer #(
    parameter int S_DATA_WIDTH = 32,
    parameter int RATIO        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    matbi_stream_downsizer_if.slave  s,
    matbi_stream_downsizer_if.master m
);
    localparam int M_DATA_WIDTH = S_DATA_WIDTH / RATIO;
    localparam int IDX_W        = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if ((RATIO < 1) || (S_DATA_WIDTH % RATIO != 0)) begin : g_bad_params
            $error("matbi_stream_downsizer: S_DATA_WIDTH must be a multiple of RATIO >= 1");
        end
    endgenerate

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t                  state;
    logic [S_DATA_WIDTH-1:0] buf_data;
    logic                    buf_last;
    logic [IDX_W-1:0]        idx;
    logic                    at_last;
    logic                    load;

    assign at_last = (idx == LAST_IDX);

    // Combinational from m.ready so a new wide beat can be taken in the same
    // cycle the final slice leaves, giving bubble-free throughput.
    assign s.ready = ~rst && ((state == EMPTY) || (m.ready && at_last));
    assign load    = s.valid && s.ready;

    assign m.valid = (state == SEND);
    assign m.last  = buf_last && at_last;

    generate
        if (RATIO == 1) begin : g_pass
            assign m.data = buf_data;
        end else begin : g_slice
            logic [RATIO-1:0][M_DATA_WIDTH-1:0] slices;
            assign slices = buf_data;
            assign m.data = slices[idx];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            idx      <= '0;
            buf_data <= '0;
            buf_last <= 1'b0;
        end else if (load) begin
            // Covers both an idle load and a reload on the final-slice handshake.
            state    <= SEND;
            idx      <= '0;
            buf_data <= s.data;
            buf_last <= s.last;
        end else if ((state == SEND) && m.ready) begin
            if (at_last) begin
                state <= EMPTY;
                idx   <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_matbi_stream_downsizer.sv
module tb_matbi_stream_downsizer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matbi_stream_downsizer_if #(.DATA_WIDTH(32)) s4 ();
    matbi_stream_downsizer_if #(.DATA_WIDTH(8))  m4 ();
    matbi_stream_downsizer_if #(.DATA_WIDTH(8))  s1 ();
    matbi_stream_downsizer_if #(.DATA_WIDTH(8))  m1 ();

    matbi_stream_downsizer #(.S_DATA_WIDTH(32), .RATIO(4)) dut4 (
        .clk(clk), .rst(rst), .s(s4), .m(m4)
    );
    matbi_stream_downsizer #(.S_DATA_WIDTH(8), .RATIO(1)) dut1 (
        .clk(clk), .rst(rst), .s(s1), .m(m1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: queue of narrow beats still owed downstream.
    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t q4[$];
    beat_t q1[$];
    bit    armed = 0;

    always @(negedge clk) begin
        if (armed) begin
            chk("m4_valid", m4.valid, q4.size() != 0);
            if (q4.size() != 0) begin
                chk("m4_data", m4.data, q4[0].d);
                chk("m4_last", m4.last, q4[0].l);
            end
            chk("s4_ready", s4.ready,
                !rst && (q4.size() == 0 || (q4.size() == 1 && m4.ready)));
            chk("m1_valid", m1.valid, q1.size() != 0);
            if (q1.size() != 0) begin
                chk("m1_data", m1.data, q1[0].d);
                chk("m1_last", m1.last, q1[0].l);
            end
            chk("s1_ready", s1.ready,
                !rst && (q1.size() == 0 || (q1.size() == 1 && m1.ready)));
        end
        if (rst) begin
            armed = 1;
            q4.delete();
            q1.delete();
        end else if (armed) begin
            if (m4.valid && m4.ready && q4.size() != 0) void'(q4.pop_front());
            if (s4.valid && s4.ready)
                for (int unsigned i = 0; i < 4; i++)
                    q4.push_back('{s4.data[i*8 +: 8], s4.last && (i == 3)});
            if (m1.valid && m1.ready && q1.size() != 0) void'(q1.pop_front());
            if (s1.valid && s1.ready)
                q1.push_back('{s1.data, s1.last});
        end
    end

    logic [7:0] e1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] e2 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    initial begin
        int nlast;
        rst = 1'b1;
        s4.valid = 0; s4.data = '0; s4.last = 0; m4.ready = 0;
        s1.valid = 0; s1.data = '0; s1.last = 0; m1.ready = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_s4_ready", s4.ready, 0);
        chk("rst_m4_valid", m4.valid, 0);
        chk("rst_m4_data", m4.data, 0);
        chk("rst_m4_last", m4.last, 0);
        chk("rst_s1_ready", s1.ready, 0);
        chk("rst_m1_valid", m1.valid, 0);

        // Single beat
        cyc();
        rst = 0; m4.ready = 1; m1.ready = 1;
        s4.valid = 1; s4.data = 32'h44332211; s4.last = 1;
        @(negedge clk);
        chk("single_s_ready", s4.ready, 1);
        cyc();
        s4.valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("single_valid", m4.valid, 1);
            chk("single_data", m4.data, e1[i]);
            chk("single_last", m4.last, i == 3);
            cyc();
        end
        @(negedge clk);
        chk("single_idle", m4.valid, 0);

        // Back-to-back wide beats
        cyc();
        s4.valid = 1; s4.data = 32'h44332211; s4.last = 0;
        cyc();
        s4.data = 32'h88776655; s4.last = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b2b_valid", m4.valid, 1);
            chk("b2b_data", m4.data, e2[i]);
            if (i < 3) chk("b2b_s_ready_busy", s4.ready, 0);
            if (i == 3) chk("b2b_s_ready_last", s4.ready, 1);
            cyc();
            if (i == 3) s4.valid = 0;
        end
        @(negedge clk);
        chk("b2b_idle", m4.valid, 0);

        // Backpressure on slice 0x22
        cyc();
        s4.valid = 1; s4.data = 32'h44332211; s4.last = 1;
        cyc();
        s4.valid = 0;
        @(negedge clk);
        chk("bp_first", m4.data, 8'h11);
        cyc();
        m4.ready = 0; s4.valid = 1; s4.data = 32'hDEADBEEF;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_data", m4.data, 8'h22);
            chk("bp_hold_valid", m4.valid, 1);
            chk("bp_s_ready", s4.ready, 0);
            cyc();
        end
        s4.valid = 0; m4.ready = 1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("bp_resume", m4.data, e1[i]);
            cyc();
        end
        @(negedge clk);
        chk("bp_idle", m4.valid, 0);

        // Reset mid-beat
        cyc();
        s4.valid = 1; s4.data = 32'h44332211; s4.last = 1;
        cyc();
        s4.valid = 0;
        @(negedge clk);
        chk("mid_11", m4.data, 8'h11);
        cyc();
        @(negedge clk);
        chk("mid_22", m4.data, 8'h22);
        cyc();
        rst = 1;
        @(negedge clk);
        chk("mid_rst_s_ready", s4.ready, 0);
        cyc();
        rst = 0;
        s4.valid = 1; s4.data = 32'hDDCCBBAA; s4.last = 0;
        @(negedge clk);
        chk("mid_after_valid", m4.valid, 0);
        cyc();
        s4.valid = 0;
        @(negedge clk);
        chk("mid_first_aa", m4.data, 8'hAA);
        repeat (4) cyc();

        // s_last low on all beats
        nlast = 0;
        for (int b = 0; b < 3; b++) begin
            s4.valid = 1; s4.data = $urandom; s4.last = 0;
            cyc();
            s4.valid = 0;
            repeat (4) begin
                @(negedge clk);
                if (m4.valid && m4.last) nlast++;
                cyc();
            end
        end
        chk("no_last", nlast, 0);

        // RATIO=1 instance
        s1.valid = 1; s1.data = 8'h5A; s1.last = 1;
        cyc();
        s1.valid = 0;
        @(negedge clk);
        chk("r1_valid", m1.valid, 1);
        chk("r1_data", m1.data, 8'h5A);
        chk("r1_last", m1.last, 1);
        cyc();
        @(negedge clk);
        chk("r1_idle", m1.valid, 0);
        cyc();
        s1.valid = 1;
        for (int i = 0; i < 6; i++) begin
            s1.data = 8'(i + 1); s1.last = i[0];
            @(negedge clk);
            chk("r1_sustain_ready", s1.ready, 1);
            if (i > 0) begin
                chk("r1_sustain_valid", m1.valid, 1);
                chk("r1_sustain_data", m1.data, i);
            end
            cyc();
        end
        s1.valid = 0;
        repeat (2) cyc();

        // Randomized traffic on both instances
        repeat (3000) begin
            rst      = ($urandom_range(0, 199) == 0);
            s4.valid = $urandom_range(0, 1) == 1;
            s4.data  = $urandom;
            s4.last  = $urandom_range(0, 1) == 1;
            m4.ready = $urandom_range(0, 3) != 0;
            s1.valid = $urandom_range(0, 1) == 1;
            s1.data  = 8'($urandom);
            s1.last  = $urandom_range(0, 1) == 1;
            m1.ready = $urandom_range(0, 3) != 0;
            cyc();
        end

        rst = 0; s4.valid = 0; s1.valid = 0; m4.ready = 1; m1.ready = 1;
        for (int k = 0; k < 20 && (q4.size() != 0 || q1.size() != 0); k++) cyc();
        chk("drain4", q4.size(), 0);
        chk("drain1", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
